// File: rtl/regfile_read_sb_if.sv
// regfile_read_sb_if: decode/writeback bundle for the GPR read side and pending-load scoreboard.
interface regfile_read_sb_if #(parameter int DW = 32, parameter int AW = 5);
    logic [AW-1:0] rs, rt, RFWA, issue_wa;
    logic [DW-1:0] rd1, rd2, RFWD;
    logic          RFWE, issue_ld, busy_rs, busy_rt, stall;
    modport master(output rs, rt, RFWE, RFWA, RFWD, issue_ld, issue_wa,
                   input rd1, rd2, busy_rs, busy_rt, stall);
    modport slave(input rs, rt, RFWE, RFWA, RFWD, issue_ld, issue_wa,
                  output rd1, rd2, busy_rs, busy_rt, stall);
endinterface

// File: rtl/regfile_read_sb.sv
// regfile_read_sb: 2R1W GPR file with pending-load scoreboard and stall.
// Define REGFILE_RD_BYPASS_EN for same-cycle write-through of data and busy clear.
module regfile_read_sb #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input logic clk,
    input logic rst,
    regfile_read_sb_if.slave bus
);
    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy, busy_nxt;
    logic            wr, hit_rs, hit_rt;
    assign wr = bus.RFWE && bus.RFWA != '0;
`ifdef REGFILE_RD_BYPASS_EN
    assign hit_rs = wr && bus.RFWA == bus.rs;
    assign hit_rt = wr && bus.RFWA == bus.rt;
`else
    assign hit_rs = 1'b0;
    assign hit_rt = 1'b0;
`endif
    // Set after clear: a load issued alongside a writeback to the same register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (wr) busy_nxt[bus.RFWA] = 1'b0;
        if (bus.issue_ld) busy_nxt[bus.issue_wa] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr) regs[bus.RFWA] <= bus.RFWD;
            busy <= busy_nxt;
        end
    end
    assign bus.rd1     = bus.rs == '0 ? '0 : hit_rs ? bus.RFWD : regs[bus.rs];
    assign bus.rd2     = bus.rt == '0 ? '0 : hit_rt ? bus.RFWD : regs[bus.rt];
    assign bus.busy_rs = busy[bus.rs] & ~hit_rs;
    assign bus.busy_rt = busy[bus.rt] & ~hit_rt;
    assign bus.stall   = bus.busy_rs | bus.busy_rt;
endmodule

// File: tb/tb_regfile_read_sb.sv
// tb_regfile_read_sb: table-driven directed check of regfile_read_sb, with or without REGFILE_RD_BYPASS_EN.
module tb_regfile_read_sb;
`ifdef REGFILE_RD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    regfile_read_sb_if #(.DW(32), .AW(5)) bus ();
    regfile_read_sb #(.DW(32), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        bit          rst, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ld;
        logic [4:0]  lwa, rs, rt;
        bit          chk;
        logic [31:0] e1, e2;
        bit          ebs, ebt;
    } vec_t;
    vec_t tbl [27];

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; bus.RFWE = v.we; bus.RFWA = v.wa; bus.RFWD = v.wd;
        bus.issue_ld = v.ld; bus.issue_wa = v.lwa; bus.rs = v.rs; bus.rt = v.rt;
        #1;
    endtask

    task automatic compare(input vec_t v, input int row);
        check("rd1", row, bus.rd1, v.e1);
        check("rd2", row, bus.rd2, v.e2);
        check("busy_rs", row, 32'(bus.busy_rs), 32'(v.ebs));
        check("busy_rt", row, 32'(bus.busy_rt), 32'(v.ebt));
        check("stall", row, 32'(bus.stall), 32'(v.ebs | v.ebt));
    endtask

    initial begin
        //          rst  we  wa   wd             ld  lwa rs  rt  chk e1                           e2                           ebs      ebt
        tbl[0]  = '{1, 0, 0,  0,             0, 0,  5,  31, 0, 0,                           0,                           0,       0};
        tbl[1]  = '{0, 0, 0,  0,             0, 0,  5,  31, 1, 0,                           0,                           0,       0};
        tbl[2]  = '{0, 1, 7,  32'hDEADBEEF,  0, 0,  7,  0,  1, BYP ? 32'hDEADBEEF : 32'h0,  0,                           0,       0};
        tbl[3]  = '{0, 1, 0,  32'h1234,      0, 0,  7,  0,  1, 32'hDEADBEEF,               0,                           0,       0};
        tbl[4]  = '{0, 0, 0,  0,             0, 0,  0,  7,  1, 0,                           32'hDEADBEEF,                0,       0};
        tbl[5]  = '{0, 0, 0,  0,             1, 9,  0,  9,  1, 0,                           0,                           0,       0};
        tbl[6]  = '{0, 0, 0,  0,             0, 0,  0,  9,  1, 0,                           0,                           0,       1};
        tbl[7]  = '{0, 1, 9,  32'h55,        0, 0,  0,  9,  1, 0,                           BYP ? 32'h55 : 32'h0,        0,       !BYP};
        tbl[8]  = '{0, 0, 0,  0,             0, 0,  0,  9,  1, 0,                           32'h55,                      0,       0};
        tbl[9]  = '{0, 0, 0,  0,             1, 4,  4,  0,  1, 0,                           0,                           0,       0};
        tbl[10] = '{0, 1, 4,  32'h44,        1, 4,  4,  0,  1, BYP ? 32'h44 : 32'h0,        0,                           !BYP,    0};
        tbl[11] = '{0, 0, 0,  0,             0, 0,  4,  0,  1, 32'h44,                      0,                           1,       0};
        tbl[12] = '{0, 1, 4,  32'h45,        0, 0,  4,  0,  1, BYP ? 32'h45 : 32'h44,       0,                           !BYP,    0};
        tbl[13] = '{0, 0, 0,  0,             0, 0,  4,  0,  1, 32'h45,                      0,                           0,       0};
        tbl[14] = '{0, 1, 7,  32'h77,        1, 10, 10, 7,  1, 0,                           BYP ? 32'h77 : 32'hDEADBEEF, 0,       0};
        tbl[15] = '{0, 0, 0,  0,             0, 0,  10, 7,  1, 0,                           32'h77,                      1,       0};
        tbl[16] = '{0, 0, 0,  0,             1, 12, 12, 10, 1, 0,                           0,                           0,       1};
        tbl[17] = '{1, 1, 13, 32'h99,        1, 13, 12, 7,  1, 0,                           32'h77,                      1,       0};
        tbl[18] = '{0, 0, 0,  0,             0, 0,  12, 7,  1, 0,                           0,                           0,       0};
        tbl[19] = '{0, 0, 0,  0,             0, 0,  13, 10, 1, 0,                           0,                           0,       0};
        tbl[20] = '{0, 1, 3,  32'hA5A5A5A5,  1, 3,  3,  3,  1, BYP ? 32'hA5A5A5A5 : 32'h0,  BYP ? 32'hA5A5A5A5 : 32'h0,  0,       0};
        tbl[21] = '{0, 0, 0,  0,             0, 0,  3,  3,  1, 32'hA5A5A5A5,               32'hA5A5A5A5,                1,       1};
        tbl[22] = '{0, 0, 0,  0,             1, 3,  3,  0,  1, 32'hA5A5A5A5,               0,                           1,       0};
        tbl[23] = '{0, 1, 3,  32'h5,         0, 0,  3,  0,  1, BYP ? 32'h5 : 32'hA5A5A5A5,  0,                           !BYP,    0};
        tbl[24] = '{0, 0, 0,  0,             0, 0,  3,  0,  1, 32'h5,                       0,                           0,       0};
        tbl[25] = '{0, 0, 0,  0,             1, 0,  0,  0,  1, 0,                           0,                           0,       0};
        tbl[26] = '{0, 0, 0,  0,             0, 0,  0,  0,  1, 0,                           0,                           0,       0};
        for (int i = 0; i < 27; i++) begin
            apply(tbl[i]);
            if (tbl[i].chk) compare(tbl[i], i);
        end
        // A load pending several cycles keeps stalling until its single writeback.
        apply('{0, 0, 0, 0, 1, 20, 20, 0, 1, 0, 0, 0, 0});
        for (int k = 0; k < 3; k++) begin
            apply('{0, 0, 0, 0, k == 1, 20, 20, 20, 0, 0, 0, 0, 0});
            check("held_stall", 100 + k, 32'(bus.stall), 32'h1);
            check("held_busy_rt", 100 + k, 32'(bus.busy_rt), 32'h1);
        end
        apply('{0, 1, 20, 32'hCAFE, 0, 0, 20, 20, 0, 0, 0, 0, 0});
        check("wb_stall", 103, 32'(bus.stall), BYP ? 32'h0 : 32'h1);
        check("wb_rd1", 103, bus.rd1, BYP ? 32'hCAFE : 32'h0);
        apply('{0, 0, 0, 0, 0, 0, 20, 20, 0, 0, 0, 0, 0});
        check("post_stall", 104, 32'(bus.stall), 32'h0);
        check("post_rd2", 104, bus.rd2, 32'hCAFE);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_read_sb.md
Name: regfile_read_sb

Overview:
- Register-file read side paired with the RF write-address mux: 32x32 GPR array with two combinational read ports (rs, rt) and one synchronous write port driven by RFWA/RFWD/RFWE.
- Adds a per-register pending-load scoreboard so decode can stall on reads of registers still awaiting a multi-cycle load writeback.
- Sits between decode (read addresses, load issue) and writeback (RFWA from the RF mux, RFWD, RFWE).

Parameters:
- DW, 32, data width of each register.
- NREG, 32, number of registers; address width is log2(NREG) = 5.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- rs  in  5  read address, port 1.
- rt  in  5  read address, port 2.
- rd1  out  DW  read data, port 1.
- rd2  out  DW  read data, port 2.
- RFWE  in  1  write enable from writeback.
- RFWA  in  5  write address (RF mux output: rd for R-type, rt for lw).
- RFWD  in  DW  write data.
- issue_ld  in  1  a load to issue_wa is issued this cycle.
- issue_wa  in  5  destination register of the issuing load.
- busy_rs  out  1  rs has a pending load.
- busy_rt  out  1  rt has a pending load.
- stall  out  1  busy_rs OR busy_rt.

Behaviour:
- Reset, synchronous active-high, on a rising clk with rst=1:
  - All registers are cleared to 0.
  - All busy bits are cleared.
  - rd1 and rd2 follow the cleared array (0).
  - busy_rs, busy_rt and stall are 0 from the cycle after reset.
  - rst has priority over RFWE and issue_ld in the same cycle. A load in flight when reset occurs is forgotten: its busy bit is cleared.
- Write:
  - On a rising clk, if RFWE=1 and RFWA!=0, then reg[RFWA] <= RFWD.
  - Writes to register 0 are ignored.
- Read:
  - rd1 = reg[rs] and rd2 = reg[rt], combinational, no latency.
  - Register 0 always reads 0, regardless of writes or bypass.
- Scoreboard: busy[31:1] are registered bits; busy[0] is constant 0. On each rising clk:
  - If issue_ld=1 and issue_wa!=0, busy[issue_wa] <= 1.
  - If RFWE=1 and RFWA!=0, busy[RFWA] <= 0.
  - If both events target the same address in the same cycle, set wins: busy stays 1 because a newer load is now pending.
  - Both events on different addresses are applied independently.
  - issue_ld to an already-busy register leaves it busy. A single writeback clears it; there is no counting of outstanding loads.
- Outputs:
  - busy_rs = busy[rs], busy_rt = busy[rt], stall = busy_rs | busy_rt.
  - All three are combinational from registered state plus the bypass term defined under Optional Feature.
  - rs=rt is legal: both ports return identical data and busy values.

Optional Feature:
- Macro: REGFILE_RD_BYPASS_EN.
- Defined (write-through):
  - If RFWE=1, RFWA!=0 and RFWA==rs, then rd1=RFWD in the same cycle; the same rule applies to rt/rd2.
  - A same-cycle writeback to rs forces busy_rs=0 (likewise busy_rt), so stall deasserts in the writeback cycle.
  - This holds even if issue_ld re-targets that register in the same cycle; the new busy bit becomes visible the following cycle.
- Undefined:
  - Reads return array contents only; new data is visible the cycle after the write.
  - busy_* reflects registered busy bits only, so stall deasserts one cycle after writeback.

Test Plan:
- Reset then read: assert rst 1 cycle; rs=5, rt=31 -> rd1=0, rd2=0, stall=0.
- Write/read with $0 guard:
  - RFWE=1, RFWA=7, RFWD=32'hDEADBEEF; next cycle rs=7 -> rd1=32'hDEADBEEF.
  - RFWE=1, RFWA=0, RFWD=32'h1234; next cycle rs=0 -> rd1=0.
- Load stall:
  - issue_ld=1, issue_wa=9; next cycle rt=9 -> busy_rt=1, stall=1.
  - Writeback RFWE=1, RFWA=9, RFWD=32'h55 -> stall=0 in the same cycle with REGFILE_RD_BYPASS_EN (rd2=32'h55), the next cycle without it.
- Set-wins collision:
  - busy[4]=1; same cycle issue_ld=1, issue_wa=4 and RFWE=1, RFWA=4.
  - Required: busy_rs for rs=4 is 1 on the following cycle, and reg[4] holds RFWD.
- Reset mid-load: issue_ld to register 12, then rst=1 for 1 cycle -> busy[12]=0, reg[12]=0, stall=0.
- Dual-port alias: reg[3]=32'hA5A5A5A5, rs=rt=3 -> rd1=rd2=32'hA5A5A5A5; with busy[3]=1, busy_rs=busy_rt=1.
